int_ctrl: RTL and testbench

- Receiving end of the peripheral interrupt lines, including the timer `irq`.
- Latches interrupt requests into IF (FF0F) and holds the enable mask in IE (FFFF).
- Presents a prioritized request and wake signal to the CPU core.
- Resolves the dispatch vector on the CPU's acknowledge handshake, clearing the serviced IF bit.

---
 rtl/int_ctrl.sv | 151 +++++++++++++++
 tb/tb_int_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller for the CPU core.
// Latches rising edges of the peripheral request lines into IF (FF0F) and keeps
// the enable mask in IE (FFFF). It raises int_req/wake toward the CPU and, on an
// acknowledge, resolves the highest-priority pending source into a vector,
// clearing the IF bit of the serviced source.
module int_ctrl #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter int          VEC_STRIDE = 8
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               ce,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic               cpu_sel_if,
    input  logic               cpu_sel_ie,
    input  logic               cpu_wr,
    input  logic [7:0]         cpu_di,
    output logic [7:0]         cpu_do,
    input  logic               ime,
    output logic               int_req,
    input  logic               int_ack,
    output logic [7:0]         int_vec,
    output logic               int_vec_valid,
    output logic               wake
);

    // Dispatch sequence: wait for ack, resolve on the following ce period,
    // then present the vector for one ce period.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_VECTOR  = 2'd2;

    localparam logic [NUM_IRQ-1:0] ONE = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0] if_reg, if_next;
    logic [NUM_IRQ-1:0] irq_prev_reg;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] pending_lowest;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [7:0]         ie_reg;
    logic [1:0]         state_reg, state_next;
    logic               int_req_reg;
    logic               wake_reg;
    logic [7:0]         int_vec_reg, int_vec_next;
    logic [7:0]         resolve_vec;
    logic [7:0]         vec_tab [NUM_IRQ];

    // Per-source edge detect and vector table; vector arithmetic wraps at 8 bits.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_src
            assign irq_rise[gi] = ce & irq_req[gi] & ~irq_prev_reg[gi];
            assign vec_tab[gi]  = VEC_BASE + 8'(gi * VEC_STRIDE);
        end
    endgenerate

    assign pending = if_reg & ie_reg[NUM_IRQ-1:0];

    // Isolate the lowest set pending bit (bit 0 has top priority).
    assign pending_lowest = pending & (~pending + ONE);

    // Map the winning one-hot source to its vector; nothing pending yields 0.
    always_comb begin
        resolve_vec = 8'h00;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (pending_lowest[i]) begin
                resolve_vec = vec_tab[i];
            end
        end
    end

    // Dispatch sequencing; every step waits for a ce period.
    always_comb begin
        state_next   = state_reg;
        clr_mask     = '0;
        int_vec_next = int_vec_reg;
        if (ce) begin
            case (state_reg)
                ST_IDLE: begin
                    if (int_ack) begin
                        state_next = ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    clr_mask     = pending_lowest;
                    int_vec_next = resolve_vec;
                    state_next   = ST_VECTOR;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // IF update order: dispatch clear, then CPU write overrides it, then a new
    // request edge overrides everything.
    always_comb begin
        if_next = if_reg & ~clr_mask;
        if (cpu_wr && cpu_sel_if) begin
            if_next = cpu_di[NUM_IRQ-1:0];
        end
        if_next = if_next | irq_rise;
    end

    // State registers; register writes bypass ce, edge history follows ce.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            if_reg       <= '0;
            ie_reg       <= 8'h00;
            irq_prev_reg <= '0;
            state_reg    <= ST_IDLE;
            int_vec_reg  <= 8'h00;
            int_req_reg  <= 1'b0;
            wake_reg     <= 1'b0;
        end else begin
            if_reg      <= if_next;
            state_reg   <= state_next;
            int_vec_reg <= int_vec_next;
            if (ce) begin
                irq_prev_reg <= irq_req;
            end
            if (cpu_wr && cpu_sel_ie) begin
                ie_reg <= cpu_di;
            end
            // Request is only offered while the dispatcher will be idle.
            int_req_reg <= (state_next == ST_IDLE) & ime & (|pending);
            // Wake ignores ime so HALT exits even with interrupts masked.
            wake_reg    <= |pending;
        end
    end

    // Register read mux; unused IF bits read as 1.
    always_comb begin
        if (cpu_sel_if) begin
            cpu_do = {{(8 - NUM_IRQ){1'b1}}, if_reg};
        end else if (cpu_sel_ie) begin
            cpu_do = ie_reg;
        end else begin
            cpu_do = 8'hFF;
        end
    end

    assign int_req       = int_req_reg;
    assign wake          = wake_reg;
    assign int_vec       = int_vec_reg;
    assign int_vec_valid = (state_reg == ST_VECTOR);

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed stimulus for int_ctrl, with a transaction-level model
// of IF/IE and the dispatch handshake compared against the outputs every cycle.
module tb_int_ctrl;

    localparam int VB = 'h40;
    localparam int VS = 8;

    logic       clk_sys;
    logic       reset_n;
    logic       ce;
    logic [4:0] irq_req;
    logic       cpu_sel_if;
    logic       cpu_sel_ie;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       ime;
    logic       int_req;
    logic       int_ack;
    logic [7:0] int_vec;
    logic       int_vec_valid;
    logic       wake;

    int n_assert = 0;
    int n_fail   = 0;

    int_ctrl dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ce            (ce),
        .irq_req       (irq_req),
        .cpu_sel_if    (cpu_sel_if),
        .cpu_sel_ie    (cpu_sel_ie),
        .cpu_wr        (cpu_wr),
        .cpu_di        (cpu_di),
        .cpu_do        (cpu_do),
        .ime           (ime),
        .int_req       (int_req),
        .int_ack       (int_ack),
        .int_vec       (int_vec),
        .int_vec_valid (int_vec_valid),
        .wake          (wake)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Model state: age counts ce periods since an accepted ack (0 = none).
    typedef struct packed {
        logic [4:0] ifr;
        logic [7:0] ie;
        logic [4:0] prev;
        logic [1:0] age;
        logic [7:0] vec;
        logic       req;
        logic       wk;
    } model_t;

    model_t m;

    function automatic model_t model_step(
        input model_t     s,
        input logic       ce_i,
        input logic [4:0] req_i,
        input logic       wr_i,
        input logic       sif_i,
        input logic       sie_i,
        input logic [7:0] di_i,
        input logic       ime_i,
        input logic       ack_i
    );
        model_t     n;
        logic [4:0] pend;
        logic [4:0] clr;
        logic [4:0] rise;
        logic       found;
        n     = s;
        pend  = s.ifr & s.ie[4:0];
        clr   = '0;
        rise  = '0;
        found = 1'b0;
        n.wk  = |pend;
        if (ce_i) begin
            rise   = req_i & ~s.prev;
            n.prev = req_i;
            if (s.age == 2'd0) begin
                if (ack_i) n.age = 2'd1;
            end else if (s.age == 2'd1) begin
                n.age = 2'd2;
                n.vec = 8'h00;
                for (int k = 0; k < 5; k++) begin
                    if (!found && pend[k]) begin
                        found  = 1'b1;
                        clr[k] = 1'b1;
                        n.vec  = 8'(VB + k * VS);
                    end
                end
            end else begin
                n.age = 2'd0;
            end
        end
        if (wr_i && sif_i) n.ifr = di_i[4:0];
        else               n.ifr = s.ifr & ~clr;
        n.ifr = n.ifr | rise;
        if (wr_i && sie_i) n.ie = di_i;
        n.req = (n.age == 2'd0) && ime_i && (|pend);
        return n;
    endfunction

    function automatic logic [7:0] model_do(input model_t s, input logic sif_i, input logic sie_i);
        if (sif_i)      return {3'b111, s.ifr};
        else if (sie_i) return s.ie;
        else            return 8'hFF;
    endfunction

    // Model advances on the same edges as the design, reset asynchronously.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else m <= model_step(m, ce, irq_req, cpu_wr, cpu_sel_if, cpu_sel_ie, cpu_di, ime, int_ack);
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison shortly after each active edge.
    always begin
        @(posedge clk_sys);
        #1;
        chk("cyc int_req",   {7'b0, int_req},       {7'b0, m.req});
        chk("cyc wake",      {7'b0, wake},          {7'b0, m.wk});
        chk("cyc int_vec",   int_vec,               m.vec);
        chk("cyc vec_valid", {7'b0, int_vec_valid}, {7'b0, (m.age == 2'd2)});
        chk("cyc cpu_do",    cpu_do,                model_do(m, cpu_sel_if, cpu_sel_ie));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr_if(input logic [7:0] v);
        cpu_sel_if = 1'b1; cpu_wr = 1'b1; cpu_di = v;
        tick(1);
        cpu_sel_if = 1'b0; cpu_wr = 1'b0;
        $display("write IF <= %h", v);
    endtask

    task automatic wr_ie(input logic [7:0] v);
        cpu_sel_ie = 1'b1; cpu_wr = 1'b1; cpu_di = v;
        tick(1);
        cpu_sel_ie = 1'b0; cpu_wr = 1'b0;
        $display("write IE <= %h", v);
    endtask

    task automatic rd(input logic is_if, output logic [7:0] v);
        if (is_if) cpu_sel_if = 1'b1;
        else       cpu_sel_ie = 1'b1;
        #1;
        v = cpu_do;
        cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
        $display("read %s -> %h", is_if ? "IF" : "IE", v);
    endtask

    // Pulse ack and stop on the negedge where the vector should be valid.
    task automatic do_ack();
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        tick(1);
        $display("ack -> int_vec=%h valid=%b", int_vec, int_vec_valid);
    endtask

    logic [7:0] v;

    initial begin
        reset_n = 1'b0; ce = 1'b1; irq_req = '0; cpu_sel_if = 1'b0; cpu_sel_ie = 1'b0;
        cpu_wr = 1'b0; cpu_di = 8'h00; ime = 1'b0; int_ack = 1'b0;
        tick(3);
        chk("rst int_req", {7'b0, int_req}, 8'h00);
        chk("rst int_vec", int_vec, 8'h00);
        chk("rst valid",   {7'b0, int_vec_valid}, 8'h00);
        chk("rst wake",    {7'b0, wake}, 8'h00);
        chk("rst no sel",  cpu_do, 8'hFF);
        rd(1'b1, v); chk("rst IF", v, 8'hE0);
        rd(1'b0, v); chk("rst IE", v, 8'h00);
        reset_n = 1'b1;
        ime = 1'b1;
        tick(1);

        // Timer request and dispatch.
        wr_ie(8'h04);
        irq_req[2] = 1'b1; tick(1); irq_req[2] = 1'b0; tick(1);
        rd(1'b1, v); chk("timer IF", v, 8'hE4);
        chk("timer int_req", {7'b0, int_req}, 8'h01);
        do_ack();
        chk("timer vec", int_vec, 8'h50);
        chk("timer valid", {7'b0, int_vec_valid}, 8'h01);
        rd(1'b1, v); chk("timer IF clr", v, 8'hE0);
        tick(1);

        // Priority among several pending sources.
        wr_ie(8'h1F);
        wr_if(8'h1A);
        tick(1);
        do_ack();
        chk("prio vec1", int_vec, 8'h48);
        rd(1'b1, v); chk("prio IF", v, 8'hF8);
        tick(1);
        do_ack();
        chk("prio vec2", int_vec, 8'h58);
        tick(1);

        // Cancelled dispatch: IE cleared in the ack cycle.
        wr_ie(8'h01);
        wr_if(8'h01);
        tick(1);
        int_ack = 1'b1; cpu_sel_ie = 1'b1; cpu_wr = 1'b1; cpu_di = 8'h00;
        tick(1);
        int_ack = 1'b0; cpu_sel_ie = 1'b0; cpu_wr = 1'b0;
        tick(1);
        $display("cancel ack -> int_vec=%h valid=%b", int_vec, int_vec_valid);
        chk("cancel vec", int_vec, 8'h00);
        chk("cancel valid", {7'b0, int_vec_valid}, 8'h01);
        rd(1'b1, v); chk("cancel IF", v, 8'hE1);
        tick(1);
        chk("cancel int_req", {7'b0, int_req}, 8'h00);

        // Request edge beats a CPU write of IF.
        wr_if(8'h00);
        irq_req[0] = 1'b1;
        wr_if(8'h00);
        irq_req[0] = 1'b0;
        rd(1'b1, v); chk("coll wr", v, 8'hE1);

        // Held level sets IF once only.
        wr_if(8'h00);
        irq_req[1] = 1'b1;
        tick(1);
        rd(1'b1, v); chk("level first", v, 8'hE2);
        wr_if(8'h00);
        tick(8);
        rd(1'b1, v); chk("level held", v, 8'hE0);
        irq_req[1] = 1'b0;
        tick(1);

        // Wake without ime; ack still dispatches.
        ime = 1'b0;
        wr_ie(8'h10);
        irq_req[4] = 1'b1; tick(1); irq_req[4] = 1'b0; tick(1);
        chk("wake", {7'b0, wake}, 8'h01);
        chk("wake int_req", {7'b0, int_req}, 8'h00);
        do_ack();
        chk("wake vec", int_vec, 8'h60);
        tick(1);

        // ce low freezes capture but not register writes.
        ce = 1'b0;
        irq_req[3] = 1'b1;
        tick(3);
        rd(1'b1, v); chk("ce0 no cap", v, 8'hE0);
        wr_if(8'h04);
        rd(1'b1, v); chk("ce0 write", v, 8'hE4);
        ce = 1'b1;
        tick(1);
        rd(1'b1, v); chk("ce1 cap", v, 8'hEC);
        irq_req[3] = 1'b0;
        wr_if(8'h00);
        tick(1);

        // Async reset during RESOLVE.
        ime = 1'b1;
        wr_ie(8'h01);
        wr_if(8'h01);
        tick(1);
        int_ack = 1'b1; tick(1); int_ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset -> req=%b vec=%h valid=%b wake=%b", int_req, int_vec, int_vec_valid, wake);
        chk("arst int_req", {7'b0, int_req}, 8'h00);
        chk("arst int_vec", int_vec, 8'h00);
        chk("arst valid",   {7'b0, int_vec_valid}, 8'h00);
        chk("arst wake",    {7'b0, wake}, 8'h00);
        tick(1);
        reset_n = 1'b1;
        rd(1'b1, v); chk("arst IF", v, 8'hE0);
        rd(1'b0, v); chk("arst IE", v, 8'h00);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
